// File: rtl/uart_tx_serializer.sv
// UART transmitter: frames a parallel word as start, LSB-first data, optional parity and stop bits.
// Each serial bit is held for OVERSAMPLE clocks. Define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               r_state;
    logic [SW-1:0]        r_sample;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_bit_end;
    logic w_last_stop;
    logic w_accept;

    assign w_bit_end   = (r_sample == SW'(OVERSAMPLE - 1));
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit == BW'(STOP_BITS - 1));
    // The final stop boundary counts as the first IDLE cycle, so a waiting
    // request starts the next frame there with no idle gap on the line.
    assign w_accept    = tx_start && ((r_state == S_IDLE) || w_last_stop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sample  <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads pre-edge state
            // and the acceptance block below may legally override the case arms.
            tx_done <= 1'b0;
            if (r_state != S_IDLE)
                r_sample <= w_bit_end ? '0 : r_sample + SW'(1);

            case (r_state)
                S_IDLE: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        tx_serial <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == BW'(DATA_BITS - 1)) begin
                            r_bit <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= S_PARITY;
                            tx_serial <= r_parity;
`else
                            r_state   <= S_STOP;
                            tx_serial <= 1'b1;
`endif
                        end else begin
                            r_bit     <= r_bit + BW'(1);
                            r_shift   <= r_shift >> 1;
                            tx_serial <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state   <= S_STOP;
                        tx_serial <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit == BW'(STOP_BITS - 1)) begin
                            r_bit     <= '0;
                            r_state   <= S_IDLE;
                            tx_serial <= 1'b1;
                            tx_busy   <= 1'b0;
                            tx_done   <= 1'b1;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_accept) begin
                r_state   <= S_START;
                r_sample  <= '0;
                r_bit     <= '0;
                r_shift   <= tx_data;
`ifdef UART_TX_PARITY_EN
                r_parity  <= ^tx_data;
`endif
                tx_serial <= 1'b0;
                tx_busy   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: reset, single frame, ignored start, back-to-back, mid-frame reset.
// With UART_TX_PARITY_EN defined it runs as 8E2 and adds a parity-specific frame.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int STOPB = 2;
    localparam int P_EN  = 1;
    localparam int FL    = 192;
`else
    localparam int STOPB = 1;
    localparam int P_EN  = 0;
    localparam int FL    = 160;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(STOPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line level k clocks after the accepting edge of a frame carrying d.
    function automatic logic exp_line(input logic [7:0] d, input int k);
        int b;
        b = k / 16;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (P_EN == 1 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset;
        rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst = 1'b0;
            tick();
            checks++;
            if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
                errors++;
                $display("FAIL reset cyc=%0d serial/busy/done got %b%b%b want 100", i, tx_serial, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_single_frame(input logic [7:0] d);
        tx_data = d; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int k = 0; k <= FL; k++) begin
            checks++;
            if (tx_serial !== ((k < FL) ? exp_line(d, k) : 1'b1) || tx_busy !== (k < FL) || tx_done !== (k == FL)) begin
                errors++;
                $display("FAIL frame_%h k=%0d serial/busy/done got %b%b%b want %b%b%b", d, k, tx_serial, tx_busy, tx_done,
                         (k < FL) ? exp_line(d, k) : 1'b1, k < FL, k == FL);
            end
            if (k < FL) tick();
        end
        tick();
        checks++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_%h_after done/busy got %b%b want 00", d, tx_done, tx_busy);
        end
    endtask

    task automatic test_ignored_start;
        tx_data = 8'hA5; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int k = 0; k <= FL + 20; k++) begin
            checks++;
            if (tx_serial !== ((k < FL) ? exp_line(8'hA5, k) : 1'b1) || tx_busy !== (k < FL) || tx_done !== (k == FL)) begin
                errors++;
                $display("FAIL ignored_start k=%0d serial/busy/done got %b%b%b want %b%b%b", k, tx_serial, tx_busy, tx_done,
                         (k < FL) ? exp_line(8'hA5, k) : 1'b1, k < FL, k == FL);
            end
            if (k == 49) begin tx_start = 1'b1; tx_data = 8'hFF; end
            if (k == 50) tx_start = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        int         kk;
        tx_data = 8'hA5; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int k = 0; k <= 2 * FL; k++) begin
            d  = (k < FL) ? 8'hA5 : 8'h3C;
            kk = (k < FL) ? k : k - FL;
            checks++;
            if (tx_serial !== ((k == 2 * FL) ? 1'b1 : exp_line(d, kk)) || tx_busy !== (k < 2 * FL) ||
                tx_done !== (k == FL || k == 2 * FL)) begin
                errors++;
                $display("FAIL back_to_back k=%0d serial/busy/done got %b%b%b want %b%b%b", k, tx_serial, tx_busy, tx_done,
                         (k == 2 * FL) ? 1'b1 : exp_line(d, kk), k < 2 * FL, k == FL || k == 2 * FL);
            end
            if (k == FL - 1) begin tx_start = 1'b1; tx_data = 8'h3C; end
            if (k == FL) tx_start = 1'b0;
            if (k < 2 * FL) tick();
        end
        tick();
    endtask

    task automatic test_reset_mid_frame;
        tx_data = 8'hA5; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int k = 0; k <= 200; k++) begin
            checks++;
            if (k < 70) begin
                if (tx_serial !== exp_line(8'hA5, k) || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_reset_pre k=%0d serial/busy/done got %b%b%b want %b10", k, tx_serial, tx_busy, tx_done,
                             exp_line(8'hA5, k));
                end
            end else if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
                errors++;
                $display("FAIL mid_reset_post k=%0d serial/busy/done got %b%b%b want 100", k, tx_serial, tx_busy, tx_done);
            end
            if (k == 69) rst = 1'b1;
            if (k == 70) rst = 1'b0;
            tick();
        end
        test_single_frame(8'h5A);
    endtask

    task automatic test_parity;
        tx_data = 8'h07; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int k = 0; k <= 192; k++) begin
            if (k == 16) begin
                checks++;
                if (tx_serial !== 1'b1) begin errors++; $display("FAIL parity_d0 got %b want 1", tx_serial); end
            end
            if (k == 9 * 16 + 8) begin
                checks++;
                if (tx_serial !== 1'b1) begin errors++; $display("FAIL parity_bit got %b want 1", tx_serial); end
            end
            if (k == 10 * 16 + 31) begin
                checks++;
                if (tx_serial !== 1'b1 || tx_done !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_stop2 serial/done got %b%b want 10", tx_serial, tx_done);
                end
            end
            if (k == 192) begin
                checks++;
                if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_done done/busy got %b%b want 10", tx_done, tx_busy);
                end
            end
            if (k < 192) tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_frame(8'hA5);
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmitter, the transmit-side counterpart of the 16x-oversampled receive path.
- Clocked at the same oversample clock as the receiver; each serial bit is held for OVERSAMPLE clocks.
- Latches a parallel word on a start strobe and serializes it as start bit, LSB-first data, optional parity, then stop bit(s).
- Reports busy/done to the host-side controller.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, clocks per serial bit (>=2); must match the receiver's oversample ratio.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  oversample clock (OVERSAMPLE x baud)
- rst  input  1  synchronous, active-high reset
- tx_start  input  1  request to send tx_data; sampled only in IDLE
- tx_data  input  DATA_BITS  word to send; latched on the accepting edge
- tx_serial  output  1  serial line; idles high; registered
- tx_busy  output  1  high from acceptance until frame end
- tx_done  output  1  one-cycle pulse at frame end

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: tx_serial=1, tx_busy=0, tx_done=0, state=IDLE, bit/sample counters=0, shift register=0.
- Reset mid-frame: the frame aborts with no tx_done pulse. tx_serial=1 from the edge where rst is sampled high.
- All outputs are registered; there is no combinational path from input to output.
- States: IDLE, START, DATA, PARITY (present only with the optional feature), STOP.
- IDLE:
  - tx_serial=1, tx_busy=0.
  - When tx_start=1 at edge E0: latch tx_data into the shift register and go to START.
  - From E0 onward: tx_serial=0, tx_busy=1.
- Bit timing: the sample counter counts 0..OVERSAMPLE-1. Each bit occupies exactly OVERSAMPLE clocks, and the line changes only on bit boundaries.
- START: hold 0 for OVERSAMPLE clocks, then go to DATA.
- DATA:
  - Send shift-register bit 0 first (LSB first) and shift right at each bit boundary.
  - The bit counter counts 0..DATA_BITS-1.
  - After the last data bit, go to PARITY (if enabled) or STOP.
- STOP:
  - Hold 1 for STOP_BITS*OVERSAMPLE clocks.
  - At the final boundary: go to IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Frame length:
  - tx_done is asserted at edge E0 + F*OVERSAMPLE, where F = 1 + DATA_BITS + P + STOP_BITS and P = 1 with parity, else 0.
  - Default 8N1 at 16x: tx_done at E0+160.
- Back-to-back frames:
  - tx_start=1 in the cycle tx_done=1 (first IDLE cycle) is accepted.
  - The next start bit begins immediately after the last stop bit, with no extra idle clock.
- tx_start while tx_busy=1 is ignored; there is no queuing.
- tx_data changes after acceptance have no effect on the current frame.
- tx_start held high continuously: frames repeat back-to-back, each using tx_data sampled at its own acceptance edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA, lasting OVERSAMPLE clocks.
  - Value = XOR of the latched data bits (even parity: total ones in data+parity is even).
  - Frame is F = DATA_BITS+STOP_BITS+2 bits.
- Not defined:
  - No PARITY state or parity logic; DATA goes straight to STOP.

Test Plan:
- rst high 2 cycles, then idle: tx_serial=1, tx_busy=0, tx_done=0 throughout.
- Defaults, tx_data=8'hA5, one-cycle tx_start at E0:
  - tx_serial = 0 on clocks 1..16.
  - Then bits 1,0,1,0,0,1,0,1, each 16 clocks.
  - Then 1 for 16 clocks.
  - tx_done pulses at E0+160; tx_busy is high E0+1..E0+160 (deasserts with the done edge).
- tx_start for 8'h3C asserted in the tx_done cycle of the 8'hA5 frame:
  - Second start bit begins at the next clock (line low immediately after the first frame's stop bit).
  - Second tx_done at E0+320.
- tx_start pulsed with tx_data=8'hFF at E0+50 during the 8'hA5 frame: ignored; the waveform is unchanged and only one tx_done occurs.
- rst asserted at E0+70 mid-frame: tx_serial=1 and tx_busy=0 from the next edge; no tx_done; a new tx_start afterward sends a clean frame.
- UART_TX_PARITY_EN defined, STOP_BITS=2, tx_data=8'h07:
  - Parity bit = 1.
  - Stop high for 32 clocks.
  - tx_done at E0+192.
